// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding, width defaults and the next-PC helper
// used by instr_sequencer and its PC register.
package seq_pkg;

   localparam int PC_W_DEF = 10;
   localparam int OP_W_DEF = 9;
   localparam int IMM_W    = 16;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH    = 3'd1,
      DECODE   = 3'd2,
      EXEC     = 3'd3,
      MEM_WAIT = 3'd4,
      HALT     = 3'd5
   } state_t;

   // Branch/jump target or sequential successor, computed at full immediate
   // width; the caller keeps the low PC_W bits, which gives the wrap-around.
   function automatic logic [IMM_W-1:0] next_pc(
      input logic [IMM_W-1:0] pc,
      input logic [IMM_W-1:0] imm,
      input logic             take,
      input logic             jmp
   );
      logic [IMM_W-1:0] nxt;
      if (jmp || take) begin
         nxt = pc + imm;
      end else begin
         nxt = pc + 16'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/seq_pc_reg.sv
// seq_pc_reg: program counter register with reload, relative branch/jump
// and sequential increment, all modulo 2**PC_W.
module seq_pc_reg
   import seq_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_load,
   input  logic             i_upd,
   input  logic             i_take,
   input  logic             i_jmp,
   input  logic [IMM_W-1:0] i_imm,
   output logic [PC_W-1:0]  o_pc
);

   logic [PC_W-1:0]  r_pc;
   logic [IMM_W-1:0] w_pc_ext;
   logic [IMM_W-1:0] w_next_ext;
   logic             w_unused_hi;

   // Zero-extend the PC so the shared helper can work at immediate width.
   always_comb begin
      w_pc_ext             = 16'h0000;
      w_pc_ext[PC_W-1:0]   = r_pc;
   end

   assign w_next_ext  = next_pc(w_pc_ext, i_imm, i_take, i_jmp);
   // Bits above PC_W are dropped on purpose: that truncation is the modulo.
   assign w_unused_hi = ^w_next_ext;

   // PC register: reload on start, advance when an instruction retires.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pc <= RESET_PC;
      end else if (i_load) begin
         r_pc <= RESET_PC;
      end else if (i_upd) begin
         r_pc <= w_next_ext[PC_W-1:0];
      end else begin
         r_pc <= r_pc;
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute controller for the 9-bit ISA.
// Optional build macro SEQ_PERF_CNT_EN adds cycle_cnt_o / instr_cnt_o
// performance counters; without it those ports do not exist.
module instr_sequencer
   import seq_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
   parameter int              OP_W     = OP_W_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start_i,
   input  logic [OP_W-1:0]  instr_i,
   input  logic             lut_rf_w_i,
   input  logic             lut_mem_w_i,
   input  logic             lut_mem_r_i,
   input  logic             lut_br_i,
   input  logic             lut_jmp_i,
   input  logic             lut_halt_i,
   input  logic [IMM_W-1:0] imm_pc_i,
   input  logic             alu_zero_i,
   input  logic             mem_ack_i,
   output logic [PC_W-1:0]  pc_o,
   output logic [OP_W-1:0]  op_o,
   output logic             rf_we_o,
   output logic             mem_we_o,
   output logic             mem_re_o,
   output logic             done_o
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [31:0]      cycle_cnt_o,
   output logic [31:0]      instr_cnt_o
`endif
);

   state_t          r_state;
   logic [OP_W-1:0] r_op;
   logic            r_done;
   logic            r_start_q;

   logic w_start_rise;
   logic w_in_exec;
   logic w_in_wait;
   logic w_idle_like;
   logic w_active;
   logic w_mem_acc;
   logic w_retire;
   logic w_take;
   logic w_pc_load;
   logic w_pc_upd;

   assign w_start_rise = start_i & ~r_start_q;

   // Classify the current state and derive retire / PC-control terms.
   always_comb begin
      w_in_exec   = 1'b0;
      w_in_wait   = 1'b0;
      w_idle_like = 1'b0;
      case (r_state)
         EXEC:       w_in_exec   = 1'b1;
         MEM_WAIT:   w_in_wait   = 1'b1;
         IDLE, HALT: w_idle_like = 1'b1;
         default:    w_idle_like = 1'b0;
      endcase
      w_active  = w_in_exec | w_in_wait;
      w_mem_acc = lut_mem_w_i | lut_mem_r_i;
      w_retire  = (w_in_exec & (~w_mem_acc | mem_ack_i)) | (w_in_wait & mem_ack_i);
      w_take    = lut_br_i & alu_zero_i;
      w_pc_upd  = w_retire & ~lut_halt_i;
      w_pc_load = w_idle_like & w_start_rise;
   end

   // Strobes follow the LUT only while executing; they fall the moment the
   // state register is reset, so an abandoned access never lingers.
   assign rf_we_o  = w_active & lut_rf_w_i;
   assign mem_we_o = w_active & lut_mem_w_i;
   assign mem_re_o = w_active & lut_mem_r_i;

   seq_pc_reg #(
      .PC_W     (PC_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk     (clk),
      .reset_n (reset_n),
      .i_load  (w_pc_load),
      .i_upd   (w_pc_upd),
      .i_take  (w_take),
      .i_jmp   (lut_jmp_i),
      .i_imm   (imm_pc_i),
      .o_pc    (pc_o)
   );

   // Sequencer FSM with registered instruction latch and done flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_op      <= {OP_W{1'b0}};
         r_done    <= 1'b0;
         r_start_q <= 1'b0;
      end else begin
         r_start_q <= start_i;
         case (r_state)
            IDLE: begin
               if (w_start_rise) begin
                  r_state <= FETCH;
               end else begin
                  r_state <= IDLE;
               end
            end
            FETCH: begin
               r_op    <= instr_i;
               r_state <= DECODE;
            end
            DECODE: begin
               r_state <= EXEC;
            end
            EXEC, MEM_WAIT: begin
               if (w_retire) begin
                  if (lut_halt_i) begin
                     r_state <= HALT;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= FETCH;
                  end
               end else begin
                  r_state <= MEM_WAIT;
               end
            end
            HALT: begin
               if (w_start_rise) begin
                  r_state <= FETCH;
                  r_done  <= 1'b0;
               end else begin
                  r_state <= HALT;
               end
            end
            default: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign op_o   = r_op;
   assign done_o = r_done;

`ifdef SEQ_PERF_CNT_EN
   logic [31:0] r_cycle_cnt;
   logic [31:0] r_instr_cnt;

   // Saturating run-cycle and retired-instruction counters, cleared on start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cycle_cnt <= 32'd0;
         r_instr_cnt <= 32'd0;
      end else if (w_pc_load) begin
         r_cycle_cnt <= 32'd0;
         r_instr_cnt <= 32'd0;
      end else begin
         if (!w_idle_like && (r_cycle_cnt != 32'hFFFF_FFFF)) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
         end else begin
            r_cycle_cnt <= r_cycle_cnt;
         end
         if (w_retire && (r_instr_cnt != 32'hFFFF_FFFF)) begin
            r_instr_cnt <= r_instr_cnt + 32'd1;
         end else begin
            r_instr_cnt <= r_instr_cnt;
         end
      end
   end

   assign cycle_cnt_o = r_cycle_cnt;
   assign instr_cnt_o = r_instr_cnt;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed bench for instr_sequencer. The bench plays the
// instruction ROM and a tiny decode LUT: op[8]=halt, op[7]=jump, op[6]=branch,
// op[5]=mem write, op[4]=mem read, op[3]=rf write, op[2:0]=signed PC offset.
module tb_instr_sequencer;

   logic        clk;
   logic        reset_n;
   logic        start_i;
   logic [8:0]  instr_i;
   logic        lut_rf_w, lut_mem_w, lut_mem_r, lut_br, lut_jmp, lut_halt;
   logic [15:0] imm_pc;
   logic        alu_zero_i;
   logic        mem_ack_i;
   logic [9:0]  pc_o;
   logic [8:0]  op_o;
   logic        rf_we_o, mem_we_o, mem_re_o, done_o;
`ifdef SEQ_PERF_CNT_EN
   logic [31:0] cycle_cnt_o, instr_cnt_o;
`endif

   logic [8:0] rom [1024];
   int n_checks = 0;
   int n_errors = 0;

   instr_sequencer dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start_i     (start_i),
      .instr_i     (instr_i),
      .lut_rf_w_i  (lut_rf_w),
      .lut_mem_w_i (lut_mem_w),
      .lut_mem_r_i (lut_mem_r),
      .lut_br_i    (lut_br),
      .lut_jmp_i   (lut_jmp),
      .lut_halt_i  (lut_halt),
      .imm_pc_i    (imm_pc),
      .alu_zero_i  (alu_zero_i),
      .mem_ack_i   (mem_ack_i),
      .pc_o        (pc_o),
      .op_o        (op_o),
      .rf_we_o     (rf_we_o),
      .mem_we_o    (mem_we_o),
      .mem_re_o    (mem_re_o),
      .done_o      (done_o)
`ifdef SEQ_PERF_CNT_EN
      ,
      .cycle_cnt_o (cycle_cnt_o),
      .instr_cnt_o (instr_cnt_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign instr_i = rom[pc_o];

   // Bench decode LUT driven from the latched instruction.
   always_comb begin
      lut_halt  = op_o[8];
      lut_jmp   = op_o[7];
      lut_br    = op_o[6];
      lut_mem_w = op_o[5];
      lut_mem_r = op_o[4];
      lut_rf_w  = op_o[3];
      imm_pc    = {{13{op_o[2]}}, op_o[2:0]};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
   endtask

   task automatic do_reset();
      reset_n    = 1'b0;
      start_i    = 1'b0;
      mem_ack_i  = 1'b0;
      alu_zero_i = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic launch();
      start_i = 1'b1;
      tick();
   endtask

   initial begin
      reset_n    = 1'b0;
      start_i    = 1'b0;
      mem_ack_i  = 1'b0;
      alu_zero_i = 1'b0;
      clear_rom();
      #3;
      check("rst_pc",   32'(pc_o),     32'd0);
      check("rst_op",   32'(op_o),     32'd0);
      check("rst_done", 32'(done_o),   32'd0);
      check("rst_rfwe", 32'(rf_we_o),  32'd0);
      check("rst_mwe",  32'(mem_we_o), 32'd0);

      // Two ALU ops then halt; start_i stays high the whole time.
      rom[0] = 9'h008; rom[1] = 9'h008; rom[2] = 9'h100;
      do_reset();
      launch();                                          // edge 1: FETCH pc0
      check("t1_pc0", 32'(pc_o), 32'd0);
      tick();                                            // edge 2: DECODE
      check("t1_op0", 32'(op_o), 32'h008);
      check("t1_dec_rfwe", 32'(rf_we_o), 32'd0);
      tick();                                            // edge 3: EXEC
      check("t1_exec0_rfwe", 32'(rf_we_o), 32'd1);
      tick();                                            // edge 4: FETCH pc1
      check("t1_fetch1_rfwe", 32'(rf_we_o), 32'd0);
      check("t1_pc1", 32'(pc_o), 32'd1);
      repeat (2) tick();                                 // edge 6: EXEC
      check("t1_exec1_rfwe", 32'(rf_we_o), 32'd1);
      tick();                                            // edge 7
      check("t1_pc2", 32'(pc_o), 32'd2);
      repeat (2) tick();                                 // edge 9: EXEC halt
      check("t1_halt_exec_done", 32'(done_o), 32'd0);
      check("t1_halt_exec_rfwe", 32'(rf_we_o), 32'd0);
      tick();                                            // edge 10: HALT
      check("t1_done10", 32'(done_o), 32'd1);
      check("t1_pc_halt", 32'(pc_o), 32'd2);
      repeat (3) tick();
      check("t1_done_hold", 32'(done_o), 32'd1);
      check("t1_pc_hold", 32'(pc_o), 32'd2);
      start_i = 1'b0;
      tick();
      check("t1_done_nostart", 32'(done_o), 32'd1);
      start_i = 1'b1;
      tick();                                            // restart
      check("t1_restart_done", 32'(done_o), 32'd0);
      check("t1_restart_pc", 32'(pc_o), 32'd0);

      // Conditional branch at pc 5 with offset -2.
      clear_rom();
      rom[5] = 9'h046; rom[6] = 9'h100;
      do_reset();
      launch();
      repeat (15) tick();
      check("t2_pc5", 32'(pc_o), 32'd5);
      alu_zero_i = 1'b1;
      repeat (3) tick();
      check("t2_taken", 32'(pc_o), 32'd3);
      alu_zero_i = 1'b0;
      repeat (6) tick();
      check("t2_pc5b", 32'(pc_o), 32'd5);
      repeat (3) tick();
      check("t2_not_taken", 32'(pc_o), 32'd6);
      repeat (3) tick();
      check("t2_done", 32'(done_o), 32'd1);

      // Store at pc 4 with ack arriving in the fourth strobe cycle.
      clear_rom();
      rom[4] = 9'h020; rom[5] = 9'h100;
      do_reset();
      launch();
      repeat (12) tick();
      check("t3_pc4", 32'(pc_o), 32'd4);
      tick();
      check("t3_dec_mwe", 32'(mem_we_o), 32'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         if (k == 3) mem_ack_i = 1'b1;
         check("t3_mwe_high", 32'(mem_we_o), 32'd1);
         check("t3_pc_held", 32'(pc_o), 32'd4);
         check("t3_mre_low", 32'(mem_re_o), 32'd0);
      end
      tick();
      mem_ack_i = 1'b0;
      check("t3_mwe_drop", 32'(mem_we_o), 32'd0);
      check("t3_pc5", 32'(pc_o), 32'd5);
      repeat (3) tick();
      check("t3_done", 32'(done_o), 32'd1);

      // PC wrap on increment and on forward jump.
      clear_rom();
      rom[0] = 9'h086;
      do_reset();
      launch();
      repeat (3) tick();
      check("t4_jmp_back", 32'(pc_o), 32'd1022);
      repeat (3) tick();
      check("t4_pc1023", 32'(pc_o), 32'd1023);
      repeat (3) tick();
      check("t4_inc_wrap", 32'(pc_o), 32'd0);
      rom[1022] = 9'h082;
      repeat (3) tick();
      check("t4_pc1022", 32'(pc_o), 32'd1022);
      repeat (3) tick();
      check("t4_jmp_wrap", 32'(pc_o), 32'd0);
      rom[0] = 9'h100;
      repeat (3) tick();
      check("t4_done", 32'(done_o), 32'd1);
      check("t4_pc_halt", 32'(pc_o), 32'd0);

      // Asynchronous reset while waiting on a load.
      clear_rom();
      rom[0] = 9'h008; rom[2] = 9'h018;
      do_reset();
      launch();
      repeat (9) tick();                                 // edge 10: MEM_WAIT
      check("t5_wait_mre", 32'(mem_re_o), 32'd1);
      check("t5_wait_rfwe", 32'(rf_we_o), 32'd1);
      check("t5_wait_pc", 32'(pc_o), 32'd2);
      #2;
      reset_n = 1'b0;
      start_i = 1'b0;
      #1;
      check("t5_rst_mre", 32'(mem_re_o), 32'd0);
      check("t5_rst_rfwe", 32'(rf_we_o), 32'd0);
      check("t5_rst_pc", 32'(pc_o), 32'd0);
      check("t5_rst_op", 32'(op_o), 32'd0);
      #1;
      reset_n = 1'b1;
      repeat (4) tick();
      check("t5_idle_op", 32'(op_o), 32'd0);
      check("t5_idle_pc", 32'(pc_o), 32'd0);
      check("t5_idle_rfwe", 32'(rf_we_o), 32'd0);

      // Halt and jump in one instruction; start_i held high in HALT.
      clear_rom();
      rom[1] = 9'h182;
      do_reset();
      launch();
      repeat (3) tick();
      check("t6_pc1", 32'(pc_o), 32'd1);
      repeat (3) tick();
      check("t6_done", 32'(done_o), 32'd1);
      check("t6_pc_kept", 32'(pc_o), 32'd1);
      repeat (4) tick();
      check("t6_no_restart", 32'(done_o), 32'd1);
      check("t6_pc_still", 32'(pc_o), 32'd1);
      check("t6_op", 32'(op_o), 32'h182);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
